// File: rtl/codigo_serializador.sv
// Serial transmit stage: captures 4-bit code words on ready rising edges into a
// 2-entry FIFO and sends each as start, 4 data bits LSB-first, even parity, stop.
module codigo_serializador #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic S0,
  input  logic S1,
  input  logic S2,
  input  logic S3,
  input  logic ready,
  output logic TX,
  output logic BUSY,
  output logic FULL,
  output logic OVF
);

  // state  | meaning
  // IDLE   | line high, waiting for a queued word
  // START  | start bit (0)
  // DATA   | 4 data bits, LSB first
  // PARITY | even parity bit
  // STOP   | stop bit (1); pops the next word here for back-to-back frames
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLKS_PER_BIT - 1);

  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [1:0]  bit_q, bit_d;
  logic [3:0]  shift_q, shift_d;
  logic        par_q, par_d;
  logic        tx_q, tx_d;
  logic        ovf_q, ovf_d;
  logic        ready_hist_q;
  logic [3:0]  mem_q [2];
  logic [3:0]  mem_d [2];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q, count_d;

  logic        capture, push, pop, div_last, fifo_full;
  logic [3:0]  word_in, head;

  assign word_in   = {S3, S2, S1, S0};
  assign head      = mem_q[rd_ptr_q];
  assign div_last  = (div_q == DIV_LAST);
  assign fifo_full = (count_q == 2'd2);
  assign capture   = ready & ~ready_hist_q;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        div_d = '0;
        tx_d  = 1'b1;
        if (count_q != 2'd0) begin
          pop     = 1'b1;
          shift_d = head;
          par_d   = ^head;
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (div_last) begin
          div_d   = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      DATA: begin
        if (div_last) begin
          div_d = '0;
          if (bit_q == 2'd3) begin
            tx_d    = par_q;
            state_d = PARITY;
          end else begin
            bit_d   = bit_q + 2'd1;
            shift_d = {1'b0, shift_q[3:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      PARITY: begin
        if (div_last) begin
          div_d   = '0;
          tx_d    = 1'b1;
          state_d = STOP;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      STOP: begin
        if (div_last) begin
          div_d = '0;
          if (count_q != 2'd0) begin
            pop     = 1'b1;
            shift_d = head;
            par_d   = ^head;
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      default: begin
        div_d   = '0;
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // A pop on the same edge frees a slot, so a push into a full FIFO is then accepted.
  always_comb begin
    push     = capture & (~fifo_full | pop);
    ovf_d    = capture & fifo_full & ~pop;
    mem_d    = mem_q;
    if (push) mem_d[wr_ptr_q] = word_in;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    count_d  = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      div_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      tx_q         <= 1'b1;
      ovf_q        <= 1'b0;
      ready_hist_q <= 1'b1;
      mem_q        <= '{default: '0};
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      tx_q         <= tx_d;
      ovf_q        <= ovf_d;
      ready_hist_q <= ready;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  assign TX   = tx_q;
  assign OVF  = ovf_q;
  assign FULL = fifo_full;
  assign BUSY = (state_q != IDLE) || (count_q != 2'd0);

endmodule
